cpu_clock_ctrl: RTL and testbench

CPU clock controller for the 68k core. Generates the CPU clock from the 50 MHz board clock with a run-time programmable half-period. Divisor changes are applied glitch-free at period boundaries, and slow peripherals can stretch the low phase. It also sequences the CPU reset release so that it lands on a clock falling edge after a fixed number of CPU clocks. Sits between the board oscillator input and the 68k CLK and RESET/HALT pins, and is configured by the system control register block.

---
 rtl/cpu_clock_ctrl_if.sv | 26 ++
 rtl/cpu_clock_ctrl.sv | 123 ++++++++++++
 tb/tb_cpu_clock_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_clock_ctrl_if.sv
// CPU clock controller interface: configuration/stretch inputs from the
// system side and the generated CPU clock, strobes and reset going out.
interface cpu_clock_ctrl_if #(
  parameter int DIV_W = 5
);
  logic [DIV_W-1:0] div_half;
  logic             div_load;
  logic             stretch_req;
  logic             clk_out;
  logic             clk_rise;
  logic             clk_fall;
  logic             cpu_reset_n;
  logic             div_busy;

  // system control side drives configuration and observes the clock
  modport master (
    output div_half, div_load, stretch_req,
    input  clk_out, clk_rise, clk_fall, cpu_reset_n, div_busy
  );

  // clock controller side
  modport slave (
    input  div_half, div_load, stretch_req,
    output clk_out, clk_rise, clk_fall, cpu_reset_n, div_busy
  );
endinterface

// File: rtl/cpu_clock_ctrl.sv
// 68k CPU clock controller: programmable half-period divider with
// glitch-free divisor switching at the start of a period, low-phase
// stretching for slow peripherals, and a reset sequencer that releases
// cpu_reset_n together with a clk_out falling edge.
module cpu_clock_ctrl #(
  parameter int DIV_W        = 5,
  parameter int DEFAULT_HALF = 5,
  parameter int RST_CYCLES   = 16
) (
  input logic             clk_in,
  input logic             reset,
  cpu_clock_ctrl_if.slave bus
);
  // rst_cnt must hold RST_CYCLES without wrapping
  localparam int RW = $clog2(RST_CYCLES + 1);
  // a zero half-period would never reach terminal count, so clamp to 1
  localparam logic [DIV_W-1:0] HALF_INIT =
    (DEFAULT_HALF == 0) ? DIV_W'(1) : DIV_W'(DEFAULT_HALF);

  typedef enum logic {
    SEQ_HOLD = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_t;

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] pending;
  logic [DIV_W-1:0] load_val;
  logic             clk_q;
  logic             rise_q;
  logic             fall_q;
  logic             busy_q;
  logic             terminal;
  logic             hold;
  logic             toggle;
  logic             do_fall;
  logic             do_rise;
  seq_t             seq_st, seq_nx;
  logic [RW-1:0]    rst_cnt, rst_cnt_nx;

  // terminal/stretch/toggle decode shared by divider, divisor and sequencer
  always_comb begin
    terminal = (cnt == (half - DIV_W'(1)));
    hold     = terminal && !clk_q && bus.stretch_req;
    toggle   = terminal && !hold;
    do_fall  = toggle && clk_q;
    do_rise  = toggle && !clk_q;
    load_val = (bus.div_half == '0) ? DIV_W'(1) : bus.div_half;
  end

  // half-period counter, registered CPU clock and edge strobes
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      clk_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      if (toggle)
        cnt <= '0;
      else if (!hold)
        cnt <= cnt + DIV_W'(1);
      clk_q  <= clk_q ^ toggle;
      rise_q <= do_rise;
      fall_q <= do_fall;
    end
  end

  // divisor staging: new values wait in pending and only take effect at a
  // fall, so the high phase in progress always completes with the old half
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      half    <= HALF_INIT;
      pending <= HALF_INIT;
      busy_q  <= 1'b0;
    end else begin
      if (do_fall)
        half <= pending;
      if (bus.div_load)
        pending <= load_val;
      // a load coinciding with a fall keeps busy set for the new value
      if (bus.div_load)
        busy_q <= 1'b1;
      else if (do_fall)
        busy_q <= 1'b0;
    end
  end

  // reset sequencer state register
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      seq_st  <= SEQ_HOLD;
      rst_cnt <= '0;
    end else begin
      seq_st  <= seq_nx;
      rst_cnt <= rst_cnt_nx;
    end
  end

  // count falls while held; the RST_CYCLES-th fall releases the CPU reset
  always_comb begin
    seq_nx     = seq_st;
    rst_cnt_nx = rst_cnt;
    case (seq_st)
      SEQ_HOLD: begin
        if (do_fall) begin
          rst_cnt_nx = rst_cnt + RW'(1);
          if (rst_cnt == RW'(RST_CYCLES - 1))
            seq_nx = SEQ_RUN;
        end
      end
      SEQ_RUN: seq_nx = SEQ_RUN;
      default: seq_nx = SEQ_HOLD;
    endcase
  end

  assign bus.clk_out     = clk_q;
  assign bus.clk_rise    = rise_q;
  assign bus.clk_fall    = fall_q;
  assign bus.div_busy    = busy_q;
  assign bus.cpu_reset_n = (seq_st == SEQ_RUN);

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Bench for cpu_clock_ctrl: each test pushes the expected sequence of
// clk_out phases (new level, phase length, cpu_reset_n, div_busy) when it
// drives stimulus; a monitor pops and compares on every clk_out transition.
module tb_cpu_clock_ctrl;
  localparam int DIV_W = 5;

  typedef struct {
    bit lvl;
    int len;
    bit rn;
    bit busy;
  } ph_t;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   mc      = 0;
  int   cyc     = 0;
  int   last_e  = 0;
  bit   prev_clk = 1'b0;
  ph_t  exp_q[$];
  ph_t  e;

  cpu_clock_ctrl_if #(.DIV_W(DIV_W)) bus ();

  cpu_clock_ctrl #(
    .DIV_W(DIV_W),
    .DEFAULT_HALF(5),
    .RST_CYCLES(16)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push(input bit lvl, input int len, input bit rn, input bit busy);
    ph_t p;
    p.lvl = lvl; p.len = len; p.rn = rn; p.busy = busy;
    exp_q.push_back(p);
  endtask

  // inputs change 1 ns after the falling edge, after the monitor sampled
  task automatic tick();
    @(negedge clk_in);
    #1;
    mc++;
  endtask

  task automatic run_to(input int edge_n);
    while (mc < edge_n) tick();
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    #1;
    bus.div_load = 1'b0;
    bus.stretch_req = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mc = 0;
  endtask

  task automatic wait_q(input int lim);
    int n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      tick();
      n++;
    end
    chk("q_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // default-divisor phases including the reset release on the 16th fall
  task automatic push_default(input int n);
    for (int i = 0; i < n; i++)
      push((i % 2) == 0, 5, i >= 31, 1'b0);
  endtask

  // phase monitor: cyc is the number of clk_in edges since reset release
  always begin
    @(negedge clk_in);
    if (reset) begin
      cyc = 0;
      last_e = 0;
      prev_clk = 1'b0;
    end else begin
      cyc++;
      if (bus.clk_out != prev_clk) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("edge_level", bus.clk_out, e.lvl);
          chk("phase_len", cyc - last_e, e.len);
          chk("rise_strobe", bus.clk_rise, e.lvl);
          chk("fall_strobe", bus.clk_fall, !e.lvl);
          chk("cpu_reset_n", bus.cpu_reset_n, e.rn);
          chk("div_busy", bus.div_busy, e.busy);
        end
        last_e = cyc;
      end else if (exp_q.size() > 0) begin
        chk("rise_idle", bus.clk_rise, 0);
        chk("fall_idle", bus.clk_fall, 0);
      end
      prev_clk = bus.clk_out;
    end
  end

  initial begin
    bus.div_half = '0;
    bus.div_load = 1'b0;
    bus.stretch_req = 1'b0;

    // reset state, applied with no clock edge
    #2 reset = 1'b1;
    #1;
    chk("rst_clk_out", bus.clk_out, 0);
    chk("rst_rise", bus.clk_rise, 0);
    chk("rst_fall", bus.clk_fall, 0);
    chk("rst_cpu_reset_n", bus.cpu_reset_n, 0);
    chk("rst_busy", bus.div_busy, 0);

    // default run and reset sequence: 16th fall at edge 160
    @(negedge clk_in);
    #1;
    reset = 1'b0;
    mc = 0;
    push_default(36);
    wait_q(400);
    chk("rn_stays", bus.cpu_reset_n, 1);

    // divisor change during a high phase; last of two loads wins
    do_reset();
    push(1, 5, 0, 0); push(0, 5, 0, 0);
    for (int i = 0; i < 3; i++) begin
      push(1, 2, 0, 0);
      push(0, 2, 0, 0);
    end
    run_to(5);
    bus.div_half = 5'd6; bus.div_load = 1'b1;
    run_to(6);
    bus.div_half = 5'd2;
    run_to(7);
    bus.div_load = 1'b0;
    chk("busy_after_load", bus.div_busy, 1);
    run_to(9);
    chk("busy_before_fall", bus.div_busy, 1);
    wait_q(60);

    // stretch at low terminal, high-phase pulse, and carried-over stretch
    do_reset();
    push(1, 5, 0, 0); push(0, 5, 0, 0);
    push(1, 12, 0, 0); push(0, 5, 0, 0);
    push(1, 5, 0, 0); push(0, 5, 0, 0);
    push(1, 5, 0, 0); push(0, 5, 0, 0);
    push(1, 7, 0, 0); push(0, 5, 0, 0);
    run_to(14); bus.stretch_req = 1'b1;
    run_to(21); bus.stretch_req = 1'b0;
    run_to(32); bus.stretch_req = 1'b1;
    run_to(35); bus.stretch_req = 1'b0;
    run_to(44); bus.stretch_req = 1'b1;
    run_to(53); bus.stretch_req = 1'b0;
    wait_q(60);

    // zero divisor means 1; a load at the applying fall stays pending
    do_reset();
    push(1, 5, 0, 1); push(0, 5, 0, 1);
    push(1, 1, 0, 1); push(0, 1, 0, 0);
    push(1, 3, 0, 0); push(0, 3, 0, 0); push(1, 3, 0, 0);
    run_to(1);
    bus.div_half = 5'd0; bus.div_load = 1'b1;
    run_to(2);
    bus.div_load = 1'b0;
    chk("zero_busy", bus.div_busy, 1);
    run_to(9);
    bus.div_half = 5'd3; bus.div_load = 1'b1;
    run_to(10);
    bus.div_load = 1'b0;
    chk("busy_held_at_fall", bus.div_busy, 1);
    wait_q(40);

    // async reset in a half=2 high phase with a pending divisor of 7
    do_reset();
    push(1, 5, 0, 1); push(0, 5, 0, 0);
    push(1, 2, 0, 0); push(0, 2, 0, 0); push(1, 2, 0, 0);
    run_to(1);
    bus.div_half = 5'd2; bus.div_load = 1'b1;
    run_to(2);
    bus.div_load = 1'b0;
    run_to(16);
    bus.div_half = 5'd7; bus.div_load = 1'b1;
    run_to(17);
    bus.div_load = 1'b0;
    chk("mid_q_empty", exp_q.size(), 0);
    chk("mid_clk_high", bus.clk_out, 1);
    chk("mid_busy", bus.div_busy, 1);
    reset = 1'b1;
    #1;
    chk("async_clk_out", bus.clk_out, 0);
    chk("async_cpu_reset_n", bus.cpu_reset_n, 0);
    chk("async_busy", bus.div_busy, 0);
    tick();
    tick();
    reset = 1'b0;
    mc = 0;
    exp_q.delete();
    push_default(34);
    wait_q(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
